// File: rtl/traffic_pkg.sv
// ============================================================================
// Module   : traffic_pkg
// Purpose  : Shared types, light codes and helpers for traffic_phase_scheduler.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_GREEN    = 3'd2,
    ST_YELLOW   = 3'd3,
    ST_ALLRED   = 3'd4,
    ST_EM_GREEN = 3'd5
  } state_e;

  typedef logic [1:0] appr_t;

  localparam logic [2:0]  LT_RED        = 3'b100;
  localparam logic [2:0]  LT_YEL        = 3'b010;
  localparam logic [2:0]  LT_GRN        = 3'b001;
  localparam logic [11:0] LIGHTS_ALLRED = {4{LT_RED}};

  // Approach A occupies the top three bits, D the bottom three.
  function automatic logic [2:0] dens_of(input logic [11:0] dens, input appr_t idx);
    return 3'(dens >> (3 * (3 - int'(idx))));
  endfunction

  function automatic logic [1:0] level(input logic [2:0] d);
    return 2'(d[0]) + 2'(d[1]) + 2'(d[2]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_phase_scheduler_select.sv
// ============================================================================
// Module   : phase_select
// Purpose  : Combinational winner pick: aged approaches first, else highest
//            density level with ties broken round-robin after the last winner.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module phase_select
  import traffic_pkg::*;
#(
  parameter int MAX_SKIP = 3
) (
  input  logic [11:0] dens_i,
  input  appr_t       last_i,
  input  logic [7:0]  skip_i,
  output appr_t       winner_o,
  output logic        any_req_o
);

  logic [1:0] lvl [4];

  always_comb begin
    for (int i = 0; i < 4; i++) lvl[i] = level(dens_of(dens_i, appr_t'(i)));
  end

  always_comb begin
    appr_t      cand;
    logic [1:0] best;
    cand      = last_i;
    best      = 2'd0;
    winner_o  = last_i;
    // Strict '>' keeps the earliest approach in round-robin order on ties.
    for (int k = 1; k <= 4; k++) begin
      cand = last_i + appr_t'(k);
      if (lvl[cand] > best) begin
        best     = lvl[cand];
        winner_o = cand;
      end
    end
    any_req_o = (best != 2'd0);
    for (int i = 3; i >= 0; i--) begin
      if (MAX_SKIP > 0 && lvl[i] != 2'd0 && int'(skip_i[2*i +: 2]) >= MAX_SKIP)
        winner_o = appr_t'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/traffic_phase_scheduler.sv
// ============================================================================
// Module   : traffic_phase_scheduler
// Purpose  : Density-sized green phases with emergency preemption for a
//            4-approach intersection. Optional macro AGE_EN adds starvation aging.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int TICK_W     = 8,
  parameter int MIN_GREEN  = 4,
  parameter int UNIT_GREEN = 4,
  parameter int MAX_GREEN  = 16,
  parameter int YELLOW_T   = 3,
  parameter int ALLRED_T   = 1,
  parameter int MAX_SKIP   = 3
) (
  input  logic        clock_i,
  input  logic        clear_n_i,
  input  logic        tick_i,
  input  logic [11:0] dens_i,
  input  logic [3:0]  em_req_i,
  output logic [11:0] lights_o,
  output appr_t       owner_o,
  output logic        phase_active_o,
  output logic        em_active_o
);

  localparam logic [TICK_W-1:0] MIN_T  = TICK_W'(MIN_GREEN);
  localparam logic [TICK_W-1:0] UNIT_T = TICK_W'(UNIT_GREEN);
  localparam logic [TICK_W-1:0] MAX_T  = TICK_W'(MAX_GREEN);
  localparam logic [TICK_W-1:0] YEL_T  = TICK_W'(YELLOW_T);
  localparam logic [TICK_W-1:0] AR_T   = TICK_W'(ALLRED_T);

  state_e            state_q, state_d;
  appr_t             owner_q, owner_d, last_q, last_d;
  logic [TICK_W-1:0] timer_q, timer_d, el_q, el_d;
  logic              em_active_q, em_active_d;

  appr_t             winner, em_idx;
  logic              any_req, em_any, timer_zero;
  logic [1:0]        lvl_own, lvl_win;
  logic [TICK_W-1:0] green_raw, green_load;
  logic [7:0]        skip;
  logic [2:0]        light_code;

  phase_select #(.MAX_SKIP(MAX_SKIP)) u_select (
    .dens_i    (dens_i),
    .last_i    (last_q),
    .skip_i    (skip),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  assign em_any     = |em_req_i;
  assign timer_zero = (timer_q == '0);
  assign lvl_own    = level(dens_of(dens_i, owner_q));
  assign lvl_win    = level(dens_of(dens_i, winner));
  assign green_raw  = MIN_T + UNIT_T * TICK_W'(lvl_win);
  assign green_load = (green_raw > MAX_T) ? MAX_T : green_raw;

  always_comb begin
    em_idx = '0;
    for (int i = 3; i >= 0; i--) if (em_req_i[i]) em_idx = appr_t'(i);
  end

  always_ff @(posedge clock_i or negedge clear_n_i) begin
    if (!clear_n_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      last_q      <= 2'd3;
      timer_q     <= '0;
      el_q        <= '0;
      em_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      timer_q     <= timer_d;
      el_q        <= el_d;
      em_active_q <= em_active_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    em_active_d = em_active_q;
    case (state_q)
      ST_IDLE: begin
        if (em_any) begin
          state_d     = ST_EM_GREEN;
          owner_d     = em_idx;
          em_active_d = 1'b1;
        end else if (any_req) begin
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        state_d = ST_GREEN;
        owner_d = winner;
        last_d  = winner;
      end
      ST_GREEN: begin
        // An emergency for the owner keeps its green; any other cuts the phase short.
        if (em_any) begin
          em_active_d = 1'b1;
          state_d     = (em_idx == owner_q) ? ST_EM_GREEN : ST_YELLOW;
        end else if (timer_zero || (el_q >= MIN_T && lvl_own == 2'd0)) begin
          state_d = ST_YELLOW;
        end
      end
      ST_YELLOW: if (timer_zero) state_d = ST_ALLRED;
      ST_ALLRED: begin
        if (timer_zero) begin
          em_active_d = em_any;
          if (em_any) begin
            state_d = ST_EM_GREEN;
            owner_d = em_idx;
          end else if (any_req) begin
            state_d = ST_SELECT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_EM_GREEN: if (!em_req_i[owner_q]) state_d = ST_YELLOW;
      default:     state_d = ST_IDLE;
    endcase
  end

  // el counts ticks since green entry, saturating once gap-out is permitted.
  always_comb begin
    timer_d = timer_q;
    el_d    = el_q;
    if (state_d != state_q) begin
      el_d = '0;
      case (state_d)
        ST_GREEN:  timer_d = green_load;
        ST_YELLOW: timer_d = YEL_T;
        ST_ALLRED: timer_d = AR_T;
        default:   timer_d = '0;
      endcase
    end else if (tick_i) begin
      if (!timer_zero) timer_d = timer_q - 1'b1;
      if (el_q < MIN_T) el_d = el_q + 1'b1;
    end
  end

`ifdef AGE_EN
  logic [7:0] skip_q, skip_d;

  always_comb begin
    skip_d = skip_q;
    for (int i = 0; i < 4; i++) begin
      if (level(dens_of(dens_i, appr_t'(i))) == 2'd0) begin
        skip_d[2*i +: 2] = 2'd0;
      end else if (state_q == ST_SELECT) begin
        if (appr_t'(i) == winner) skip_d[2*i +: 2] = 2'd0;
        else if (skip_q[2*i +: 2] != 2'd3) skip_d[2*i +: 2] = skip_q[2*i +: 2] + 2'd1;
      end
    end
  end

  always_ff @(posedge clock_i or negedge clear_n_i) begin
    if (!clear_n_i) skip_q <= '0;
    else            skip_q <= skip_d;
  end

  assign skip = skip_q;
`else
  assign skip = '0;
`endif

  always_comb begin
    lights_o       = LIGHTS_ALLRED;
    phase_active_o = 1'b0;
    light_code     = LT_RED;
    case (state_q)
      ST_GREEN, ST_EM_GREEN: begin
        light_code     = LT_GRN;
        phase_active_o = 1'b1;
      end
      ST_YELLOW: begin
        light_code     = LT_YEL;
        phase_active_o = 1'b1;
      end
      default: light_code = LT_RED;
    endcase
    for (int i = 0; i < 4; i++) begin
      if (appr_t'(i) == owner_q) lights_o[3*(3-i) +: 3] = light_code;
    end
  end

  assign owner_o     = owner_q;
  assign em_active_o = em_active_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_scheduler.sv
// ============================================================================
// Module   : tb_traffic_phase_scheduler
// Purpose  : Directed self-checking bench for traffic_phase_scheduler.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_traffic_phase_scheduler;

  localparam logic [11:0] AR   = 12'b100100100100;
  localparam logic [11:0] A_G  = 12'b001100100100;
  localparam logic [11:0] A_Y  = 12'b010100100100;
  localparam logic [11:0] B_G  = 12'b100001100100;
  localparam logic [11:0] B_Y  = 12'b100010100100;
  localparam logic [11:0] C_G  = 12'b100100001100;
  localparam logic [11:0] C_Y  = 12'b100100010100;
  localparam logic [11:0] D_G  = 12'b100100100001;
  localparam logic [11:0] D_Y  = 12'b100100100010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic [11:0] dens = '0;
  logic [3:0]  em = '0;
  logic [11:0] lights;
  logic [1:0]  owner;
  logic        pa, ea;
  int          checks = 0;
  int          failures = 0;
  logic [1:0]  age_exp;

  always #5 clk = ~clk;

  traffic_phase_scheduler dut (
    .clock_i        (clk),
    .clear_n_i      (rst_n),
    .tick_i         (tick),
    .dens_i         (dens),
    .em_req_i       (em),
    .lights_o       (lights),
    .owner_o        (owner),
    .phase_active_o (pa),
    .em_active_o    (ea)
  );

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      clk1();
      tick = 1'b0;
      clk1();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    dens  = '0;
    em    = '0;
    tick  = 1'b0;
    clk1();
    clk1();
    rst_n = 1'b1;
    clk1();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    clk1();
    check("rst_lights", lights, AR);
    check("rst_owner", 12'(owner), 12'd0);
    check("rst_pa", 12'(pa), 12'd0);
    check("rst_ea", 12'(ea), 12'd0);
    rst_n = 1'b1;
    clk1();

    // A alone at level 2: 12-tick green, 3-tick yellow, 1-tick all-red
    dens = 12'b110_000_000_000;
    clk1();
    check("a_select_allred", lights, AR);
    clk1();
    check("a_green", lights, A_G);
    check("a_owner", 12'(owner), 12'd0);
    check("a_pa", 12'(pa), 12'd1);
    ticks(11);
    check("a_green_t11", lights, A_G);
    ticks(1);
    check("a_yellow", lights, A_Y);
    dens = '0;
    ticks(2);
    check("a_yellow_t2", lights, A_Y);
    ticks(1);
    check("a_allred", lights, AR);
    check("a_allred_pa", 12'(pa), 12'd0);
    ticks(1);
    check("a_idle", lights, AR);

    // Asynchronous reset in the middle of a green
    dens = 12'b110_000_000_000;
    clk1();
    clk1();
    ticks(2);
    check("mid_green", lights, A_G);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_lights", lights, AR);
    check("async_rst_pa", 12'(pa), 12'd0);
    check("async_rst_owner", 12'(owner), 12'd0);
    do_reset();

    // A and C tied at level 3: alternate A,C,A,C with saturated 16-tick greens
    dens = 12'b111_000_111_000;
    clk1();
    clk1();
    check("tie1_owner", 12'(owner), 12'd0);
    check("tie1_lights", lights, A_G);
    ticks(15);
    check("tie1_green_t15", lights, A_G);
    ticks(1);
    check("tie1_yellow_t16", lights, A_Y);
    ticks(3);
    check("tie1_allred", lights, AR);
    ticks(1);
    clk1();
    check("tie2_owner", 12'(owner), 12'd2);
    check("tie2_lights", lights, C_G);
    ticks(20);
    clk1();
    check("tie3_owner", 12'(owner), 12'd0);
    ticks(20);
    clk1();
    check("tie4_owner", 12'(owner), 12'd2);
    do_reset();

    // Gap-out: B level 1, request drops after 1 tick, green lasts exactly MIN_GREEN
    dens = 12'b000_100_000_000;
    clk1();
    clk1();
    check("gap_green", lights, B_G);
    ticks(1);
    dens = '0;
    ticks(2);
    check("gap_not_before_min", lights, B_G);
    ticks(1);
    check("gap_yellow", lights, B_Y);
    ticks(4);
    check("gap_idle", lights, AR);
    do_reset();

    // Preemption of C's green by an emergency on D
    dens = 12'b000_000_100_000;
    clk1();
    clk1();
    check("pre_c_green", lights, C_G);
    ticks(2);
    em = 4'b1000;
    clk1();
    check("pre_c_yellow", lights, C_Y);
    check("pre_ea_accept", 12'(ea), 12'd1);
    ticks(3);
    check("pre_allred", lights, AR);
    ticks(1);
    check("pre_em_green", lights, D_G);
    check("pre_em_owner", 12'(owner), 12'd3);
    check("pre_em_pa", 12'(pa), 12'd1);
    ticks(5);
    check("pre_em_hold", lights, D_G);
    em = 4'b1001;
    ticks(2);
    check("pre_em_new_bit_ignored", lights, D_G);
    em = 4'b0000;
    clk1();
    check("pre_em_yellow", lights, D_Y);
    check("pre_em_yellow_ea", 12'(ea), 12'd1);
    ticks(4);
    check("pre_release_ea", 12'(ea), 12'd0);
    check("pre_release_select", lights, AR);
    clk1();
    check("pre_back_to_c", lights, C_G);
    do_reset();

    // Emergency for the current owner: straight to EM_GREEN, no timer, no gap-out
    dens = 12'b010_000_000_000;
    clk1();
    clk1();
    em = 4'b0001;
    clk1();
    check("own_em_lights", lights, A_G);
    check("own_em_ea", 12'(ea), 12'd1);
    dens = '0;
    ticks(10);
    check("own_em_held", lights, A_G);
    em = 4'b0000;
    clk1();
    check("own_em_yellow", lights, A_Y);
    ticks(4);
    check("own_em_idle_ea", 12'(ea), 12'd0);
    do_reset();

    // From IDLE, emergency beats density; lowest set em bit wins
    dens = 12'b000_111_000_000;
    em   = 4'b1100;
    clk1();
    check("idle_em_lights", lights, C_G);
    check("idle_em_owner", 12'(owner), 12'd2);
    em = 4'b0000;
    clk1();
    ticks(4);
    clk1();
    check("idle_em_then_b", 12'(owner), 12'd1);
    do_reset();

    // Starvation: A level 3 against B level 1
`ifdef AGE_EN
    age_exp = 2'd1;
`else
    age_exp = 2'd0;
`endif
    dens = 12'b111_100_000_000;
    clk1();
    clk1();
    check("age_sel1", 12'(owner), 12'd0);
    ticks(20);
    clk1();
    check("age_sel2", 12'(owner), 12'd0);
    ticks(20);
    clk1();
    check("age_sel3", 12'(owner), 12'd0);
    ticks(20);
    clk1();
    check("age_sel4", 12'(owner), 12'(age_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
